// File: rtl/vend_pkg.sv
// Shared types, widths and default prices for the vending machine controller.
package vend_pkg;

    localparam int CREDIT_W = 7;

    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [1:0]          item_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DENY,
        ST_VEND,
        ST_REFUND,
        ST_CLEAR
    } vend_state_e;

    localparam int DEF_PRICE_0 = 25;
    localparam int DEF_PRICE_1 = 35;
    localparam int DEF_PRICE_2 = 50;
    localparam int DEF_PRICE_3 = 75;

    function automatic credit_t item_price(
        input item_t   item,
        input credit_t p0,
        input credit_t p1,
        input credit_t p2,
        input credit_t p3
    );
        credit_t price;
        case (item)
            2'd0:    price = p0;
            2'd1:    price = p1;
            2'd2:    price = p2;
            default: price = p3;
        endcase
        return price;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity timer: counts while run is high, flags the last counted cycle.
module vend_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Counter saturates at LAST; the controller leaves IDLE on expiry, which drops run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run || restart) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && !restart && (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencer: gates coins, checks price, dispenses, refunds and clears credit.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_0     = DEF_PRICE_0,
    parameter int PRICE_1     = DEF_PRICE_1,
    parameter int PRICE_2     = DEF_PRICE_2,
    parameter int PRICE_3     = DEF_PRICE_3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] total,
    input  logic       coin_event,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    output logic       coin_enable,
    output logic       clear,
    output logic       dispense,
    output logic [1:0] dispense_item,
    output logic       change_valid,
    output logic [6:0] change_amt,
    output logic       deny,
    output logic       busy
);

    vend_state_e state_q, state_d;
    item_t       item_q, item_d;
    credit_t     change_q, change_d;
    credit_t     price;
    logic        timer_run;
    logic        timer_expired;

    assign price = item_price(item_q, credit_t'(PRICE_0), credit_t'(PRICE_1),
                              credit_t'(PRICE_2), credit_t'(PRICE_3));

    // Idle timeout only runs while credit is held; any coin restarts it.
    assign timer_run = (state_q == ST_IDLE) && (total != '0);

    vend_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (timer_run),
        .restart (coin_event),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            item_q   <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            item_q   <= item_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        item_d        = item_q;
        change_d      = change_q;
        coin_enable   = 1'b0;
        clear         = 1'b0;
        dispense      = 1'b0;
        dispense_item = '0;
        change_valid  = 1'b0;
        change_amt    = '0;
        deny          = 1'b0;
        busy          = 1'b1;

        case (state_q)
            ST_IDLE: begin
                coin_enable = 1'b1;
                busy        = 1'b0;
                if (cancel && (total != '0)) begin
                    change_d = total;
                    state_d  = ST_REFUND;
                end else if (sel_valid) begin
                    item_d  = sel_item;
                    state_d = ST_CHECK;
                end else if (timer_expired) begin
                    change_d = total;
                    state_d  = ST_REFUND;
                end
            end
            // Coins are gated off here, so total is stable for the compare.
            ST_CHECK: begin
                if (total >= price) begin
                    change_d = total - price;
                    state_d  = ST_VEND;
                end else begin
                    state_d = ST_DENY;
                end
            end
            ST_DENY: begin
                deny    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_VEND: begin
                dispense      = 1'b1;
                dispense_item = item_q;
                state_d       = (change_q != '0) ? ST_REFUND : ST_CLEAR;
            end
            ST_REFUND: begin
                change_valid = 1'b1;
                change_amt   = change_q;
                state_d      = ST_CLEAR;
            end
            ST_CLEAR: begin
                clear   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus randomized transactions.
module tb_vend_controller;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] total;
    logic       coin_event;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       coin_enable;
    logic       clear;
    logic       dispense;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [6:0] change_amt;
    logic       deny;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int price[4] = '{25, 35, 50, 75};

    logic [14:0] obs;
    assign obs = {busy, coin_enable, clear, dispense, dispense_item, change_valid, change_amt, deny};

    vend_controller #(
        .PRICE_0     (25),
        .PRICE_1     (35),
        .PRICE_2     (50),
        .PRICE_3     (75),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .total         (total),
        .coin_event    (coin_event),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .coin_enable   (coin_enable),
        .clear         (clear),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_amt    (change_amt),
        .deny          (deny),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ov(input logic b, input logic ce, input logic clr,
                                       input logic disp, input logic [1:0] it, input logic cv,
                                       input logic [6:0] amt, input logic dn);
        return {b, ce, clr, disp, it, cv, amt, dn};
    endfunction

    function automatic logic [14:0] vIdle();
        return ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 1'b0);
    endfunction
    function automatic logic [14:0] vBusy();
        return ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 1'b0);
    endfunction
    function automatic logic [14:0] vDeny();
        return ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 1'b1);
    endfunction
    function automatic logic [14:0] vVend(input logic [1:0] it);
        return ov(1'b1, 1'b0, 1'b0, 1'b1, it, 1'b0, 7'd0, 1'b0);
    endfunction
    function automatic logic [14:0] vRefund(input logic [6:0] amt);
        return ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, amt, 1'b0);
    endfunction
    function automatic logic [14:0] vClear();
        return ov(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 7'd0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One transaction from IDLE: expected cycle-by-cycle outputs come from the price table.
    task automatic applyStimulus(input string name, input logic [6:0] tot, input bit sel,
                                 input logic [1:0] it, input bit can, input bit noisy);
        logic [14:0] exp_q[$];
        logic [6:0]  chg;
        bit          cleared;
        cleared = 1'b0;
        if (can && tot != 7'd0) begin
            exp_q.push_back(vRefund(tot));
            exp_q.push_back(vClear());
            cleared = 1'b1;
        end else if (sel) begin
            exp_q.push_back(vBusy());
            if (int'(tot) >= price[it]) begin
                chg = 7'(int'(tot) - price[it]);
                exp_q.push_back(vVend(it));
                if (chg != 7'd0) exp_q.push_back(vRefund(chg));
                exp_q.push_back(vClear());
                cleared = 1'b1;
            end else begin
                exp_q.push_back(vDeny());
            end
        end
        exp_q.push_back(vIdle());

        total      = tot;
        sel_valid  = sel;
        sel_item   = it;
        cancel     = can;
        coin_event = 1'b0;
        tick();
        sel_valid = 1'b0;
        cancel    = 1'b0;
        foreach (exp_q[i]) begin
            checkOutput($sformatf("%s.c%0d", name, i + 1), {17'd0, obs}, {17'd0, exp_q[i]});
            if (noisy && exp_q[i][14]) begin
                sel_valid  = 1'($urandom_range(0, 1));
                sel_item   = 2'($urandom);
                cancel     = 1'($urandom_range(0, 1));
                coin_event = 1'($urandom_range(0, 1));
            end else begin
                sel_valid  = 1'b0;
                cancel     = 1'b0;
                coin_event = 1'b0;
            end
            if (i < exp_q.size() - 1) tick();
        end
        if (cleared) total = 7'd0;
    endtask

    // Idle with credit; coin_at (0 = none) is the edge carrying a coin pulse.
    task automatic checkTimeout(input string name, input logic [6:0] tot, input int coin_at);
        int          refund_edge;
        logic [14:0] want;
        refund_edge = coin_at + TO;
        total = tot;
        for (int e = 1; e <= refund_edge + 2; e++) begin
            coin_event = (e == coin_at);
            tick();
            coin_event = 1'b0;
            if (e < refund_edge)       want = vIdle();
            else if (e == refund_edge) want = vRefund(tot);
            else if (e == refund_edge + 1) want = vClear();
            else                       want = vIdle();
            checkOutput($sformatf("%s.e%0d", name, e), {17'd0, obs}, {17'd0, want});
        end
        total = 7'd0;
    endtask

    initial begin
        logic [6:0] rtot;
        int         act;
        reset      = 1'b1;
        total      = 7'd0;
        coin_event = 1'b0;
        sel_valid  = 1'b0;
        sel_item   = 2'd0;
        cancel     = 1'b0;
        tick();
        tick();
        checkOutput("reset", {17'd0, obs}, {17'd0, vIdle()});
        reset = 1'b0;
        tick();
        checkOutput("post_reset", {17'd0, obs}, {17'd0, vIdle()});

        applyStimulus("exact",       7'd25, 1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus("overpay",     7'd60, 1'b1, 2'd1, 1'b0, 1'b0);
        applyStimulus("short",       7'd30, 1'b1, 2'd2, 1'b0, 1'b0);
        checkOutput("short_total_kept", {25'd0, total}, 32'd30);
        applyStimulus("cancel",      7'd40, 1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus("cancel_zero", 7'd0,  1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus("cancel_sel",  7'd90, 1'b1, 2'd3, 1'b1, 1'b0);
        applyStimulus("item3_exact", 7'd75, 1'b1, 2'd3, 1'b0, 1'b0);
        applyStimulus("max_credit",  7'd127, 1'b1, 2'd3, 1'b0, 1'b0);
        applyStimulus("one_short",   7'd49, 1'b1, 2'd2, 1'b0, 1'b0);

        checkTimeout("timeout",      7'd10, 0);
        checkTimeout("timeout_coin", 7'd10, 5);

        // Reset while dispensing must abort without clear or change.
        total     = 7'd50;
        sel_valid = 1'b1;
        sel_item  = 2'd0;
        tick();
        sel_valid = 1'b0;
        tick();
        checkOutput("rst_vend_pre", {17'd0, obs}, {17'd0, vVend(2'd0)});
        reset = 1'b1;
        #1;
        checkOutput("rst_vend_now", {17'd0, obs}, {17'd0, vIdle()});
        tick();
        checkOutput("rst_vend_hold", {17'd0, obs}, {17'd0, vIdle()});
        #2;
        reset = 1'b0;
        total = 7'd0;
        tick();
        checkOutput("rst_vend_rel1", {17'd0, obs}, {17'd0, vIdle()});
        tick();
        checkOutput("rst_vend_rel2", {17'd0, obs}, {17'd0, vIdle()});

        for (int n = 0; n < 60; n++) begin
            rtot = 7'($urandom_range(0, 127));
            act  = $urandom_range(0, 3);
            applyStimulus($sformatf("rnd%0d", n), rtot, (act != 1), 2'($urandom),
                          (act == 1 || act == 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Top-level sequencer for the retro vending machine. Sits between the user panel and the coin credit accumulator.
- Gates coin acceptance, checks the selected item's price against the accumulated credit, and pulses dispense.
- Returns change or refunds credit on cancel or inactivity timeout, then pulses the accumulator's clear input.
- All outputs are Moore-decoded from the state register.

Parameters:
PRICE_0, 25, price of item 0 in cents (1..127)
PRICE_1, 35, price of item 1
PRICE_2, 50, price of item 2
PRICE_3, 75, price of item 3
TIMEOUT_CYC, 1000, idle cycles with non-zero credit before auto-refund (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
total  in  7  current credit from accumulator (cents)
coin_event  in  1  OR of accumulator coin pulses; restarts timeout
sel_valid  in  1  one-cycle item selection strobe
sel_item  in  2  item code, sampled with sel_valid
cancel  in  1  one-cycle refund request
coin_enable  out  1  coins may be accepted (external gating of accumulator coin inputs)
clear  out  1  one-cycle clear to accumulator
dispense  out  1  one-cycle dispense strobe
dispense_item  out  2  item being dispensed; valid with dispense
change_valid  out  1  one-cycle change/refund strobe
change_amt  out  7  change/refund amount in cents; valid with change_valid, 0 otherwise
deny  out  1  one-cycle insufficient-credit strobe
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, CHECK, DENY, VEND, REFUND, CLEAR.
- Reset: state=IDLE. dispense, clear, change_valid, deny and busy are 0. change_amt=0, dispense_item=0, latched item/change=0, timeout counter=0. coin_enable=1.
- Reset asserted mid-transaction (any state) aborts immediately: no dispense, no change, no clear pulse.
- IDLE: coin_enable=1. Priority is cancel > sel_valid > timeout.
  - cancel with total!=0: latch change=total, go to REFUND.
  - cancel with total==0: ignored.
  - sel_valid: latch sel_item, go to CHECK.
  - Timeout counter is held at 0 while total==0 or coin_event=1; otherwise it increments each IDLE cycle.
  - Counter reaching TIMEOUT_CYC-1: latch change=total, go to REFUND.
  - Counter clears on leaving IDLE.
- CHECK (1 cycle): coin_enable=0, so total is stable. Compare total >= price[item], unsigned 7-bit.
  - True: latch change=total-price (cannot underflow), go to VEND.
  - False: go to DENY.
- DENY (1 cycle): deny=1, then back to IDLE. Credit is retained and the timeout restarts from 0.
- VEND (1 cycle): dispense=1, dispense_item=latched item. Next state is REFUND if change!=0, else CLEAR.
- REFUND (1 cycle): change_valid=1, change_amt=latched change. Next state is CLEAR.
- CLEAR (1 cycle): clear=1. Next state is IDLE; the accumulator reads total=0 on the following cycle.
- Latency from sel_valid sampled at edge N:
  - CHECK at N+1, VEND at N+2, REFUND at N+3 (if change), CLEAR at N+3 or N+4, IDLE one cycle later.
- sel_valid and cancel outside IDLE are ignored, not queued.
- coin_event outside IDLE is ignored (coins are gated by coin_enable=0).
- Credit wrap above 127 is the accumulator's concern; the controller treats total as-is.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_e
  - item typedef item_t (2-bit)
  - CREDIT_W=7
  - default price constants
  - a function mapping item_t to price
- Sub-module vend_timeout_timer holds the counter, with ports clk, reset, run, restart, expired.

Test Plan:
1. Exact payment: total=25, sel_valid with item 0 -> dispense=1, item 0 at N+2; no change_valid; clear=1 at N+3; busy low at N+4.
2. Overpay: total=60, item 1 -> dispense at N+2; change_valid with change_amt=25 at N+3; clear at N+4.
3. Insufficient credit: total=30, item 2 -> deny=1 at N+2; no dispense and no clear; back in IDLE at N+3 with total still 30.
4. Cancel: total=40, cancel -> change_valid with change_amt=40 at N+1; clear at N+2.
   - Cancel with total=0 -> no outputs.
   - cancel and sel_valid in the same cycle -> refund path only.
5. Timeout with TIMEOUT_CYC=8: total=10 and no activity -> refund of 10 after 8 IDLE cycles.
   - coin_event at cycle 5 restarts the count, so the refund comes 8 cycles after the coin.
6. Reset during VEND: all outputs 0 immediately; IDLE with coin_enable=1 after release; no clear pulse emitted.
